// File: rtl/fbcpu_mem_loader.sv
// Program memory with a stream loader that holds the CPU in reset while a program is loaded.
// Optional macro FBCPU_MEM_WP_EN write-protects the loaded region against CPU stores.
module fbcpu_mem_loader #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_last,
    input  logic                     ld_start,
    output logic                     cpu_rst,
    input  logic [ADDRESS_WIDTH-1:0] MAR,
    input  logic                     RAMWr,
    input  logic [DATA_WIDTH-1:0]    MDRIn,
    output logic [DATA_WIDTH-1:0]    MDROut,
    output logic [ADDRESS_WIDTH:0]   load_len,
    output logic                     wp_hit
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        LOAD,
        RELEASE,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDRESS_WIDTH-1:0] wptr;
    logic                    ld_accept;
    logic                    cpu_write;
    logic                    wp_block;
    logic                    enter_load;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef FBCPU_MEM_WP_EN
    assign wp_block = ({1'b0, MAR} < load_len);
`else
    assign wp_block = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        cpu_rst    = 1'b1;
        ld_accept  = 1'b0;
        enter_load = 1'b0;
        cpu_write  = 1'b0;
        case (state)
            LOAD: begin
                ld_ready  = 1'b1;
                ld_accept = ld_valid;
                // The last slot ends the load even without ld_last, so wptr never wraps
                if (ld_valid && (ld_last || (wptr == '1))) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = RUN;
            end
            RUN: begin
                cpu_rst   = 1'b0;
                cpu_write = RAMWr && !wp_block;
                if (ld_start) begin
                    state_next = LOAD;
                    enter_load = 1'b1;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || enter_load) begin
            wptr     <= '0;
            load_len <= '0;
        end else if (ld_accept) begin
            load_len <= load_len + (ADDRESS_WIDTH + 1)'(1);
            if (wptr != '1) begin
                wptr <= wptr + ADDRESS_WIDTH'(1);
            end
        end
    end

    // Memory is deliberately not reset so a program survives rst
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_accept) begin
                mem[wptr] <= ld_data;
            end else if (cpu_write) begin
                mem[MAR] <= MDRIn;
            end
        end
    end

    // Read data is forced to zero whenever the next cycle is not a RUN cycle
    always_ff @(posedge clk) begin
        if (rst || (state != RUN) || (state_next != RUN)) begin
            MDROut <= '0;
        end else begin
            MDROut <= mem[MAR];
        end
    end

`ifdef FBCPU_MEM_WP_EN
    always_ff @(posedge clk) begin
        if (rst || enter_load) begin
            wp_hit <= 1'b0;
        end else if ((state == RUN) && RAMWr && wp_block) begin
            wp_hit <= 1'b1;
        end
    end
`else
    assign wp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_fbcpu_mem_loader.sv
// Self-checking bench for fbcpu_mem_loader; expectations follow FBCPU_MEM_WP_EN when defined.
module tb_fbcpu_mem_loader;

    logic       clk;
    logic       rst;
    logic       ld_valid;
    logic       ld_ready;
    logic [9:0] ld_data;
    logic       ld_last;
    logic       ld_start;
    logic       cpu_rst;
    logic [5:0] MAR;
    logic       RAMWr;
    logic [9:0] MDRIn;
    logic [9:0] MDROut;
    logic [6:0] load_len;
    logic       wp_hit;

    fbcpu_mem_loader #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .ld_start(ld_start), .cpu_rst(cpu_rst),
        .MAR(MAR), .RAMWr(RAMWr), .MDRIn(MDRIn), .MDROut(MDROut),
        .load_len(load_len), .wp_hit(wp_hit)
    );

    typedef struct {
        string      name;
        logic [5:0] mar;
        logic       wr;
        logic [9:0] din;
        logic       chk;
        logic [9:0] exp;
    } vec_t;

    localparam int NV = 11;
    vec_t        vecs [NV];
    logic [9:0]  model [64];
    logic [9:0]  expQ [$];
    int          checks = 0;
    int          errors = 0;
    int          wIdx   = 0;
    int          expLen = 0;
    logic        expWp  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [9:0] data, input logic last,
                                 input logic start, input logic [5:0] addr, input logic wr,
                                 input logic [9:0] din);
        ld_valid = valid;
        ld_data  = data;
        ld_last  = last;
        ld_start = start;
        MAR      = addr;
        RAMWr    = wr;
        MDRIn    = din;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 6'd0, 1'b0, 10'h0);
    endtask

    task automatic modelCpuWrite(input logic [5:0] a, input logic [9:0] d);
`ifdef FBCPU_MEM_WP_EN
        if (int'(a) < expLen) expWp = 1'b1;
        else model[a] = d;
`else
        model[a] = d;
`endif
    endtask

    task automatic loadWord(input logic [9:0] data, input logic last);
        model[wIdx] = data;
        wIdx++;
        expLen++;
        applyStimulus(1'b1, data, last, 1'b0, 6'd0, 1'b0, 10'h0);
    endtask

    task automatic startReload(input logic [5:0] addr, input logic wr, input logic [9:0] din);
        if (wr) modelCpuWrite(addr, din);
        applyStimulus(1'b0, 10'h0, 1'b0, 1'b1, addr, wr, din);
        wIdx   = 0;
        expLen = 0;
        expWp  = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [5:0] addr);
        expQ.push_back(model[addr]);
        applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, addr, 1'b0, 10'h0);
        checkOutput(name, MDROut, expQ.pop_front());
    endtask

    initial begin
        vecs[0]  = '{"rd1",   6'd1,  1'b0, 10'h000, 1'b1, 10'h0C5};
        vecs[1]  = '{"rd0",   6'd0,  1'b0, 10'h000, 1'b1, 10'h040};
        vecs[2]  = '{"rd2",   6'd2,  1'b0, 10'h000, 1'b1, 10'h200};
        vecs[3]  = '{"wr10",  6'd10, 1'b1, 10'h155, 1'b0, 10'h000};
        vecs[4]  = '{"rd10",  6'd10, 1'b0, 10'h000, 1'b1, 10'h155};
        vecs[5]  = '{"rbw10", 6'd10, 1'b1, 10'h0AA, 1'b1, 10'h155};
        vecs[6]  = '{"rd10b", 6'd10, 1'b0, 10'h000, 1'b1, 10'h0AA};
        vecs[7]  = '{"wr5",   6'd5,  1'b1, 10'h123, 1'b0, 10'h000};
        vecs[8]  = '{"rd5",   6'd5,  1'b0, 10'h000, 1'b1, 10'h123};
        vecs[9]  = '{"wr21",  6'd21, 1'b1, 10'h0F0, 1'b0, 10'h000};
        vecs[10] = '{"rd10c", 6'd10, 1'b0, 10'h000, 1'b1, 10'h0AA};

        rst = 1'b1;
        idle();
        idle();
        checkOutput("rst_ld_ready", ld_ready, 1);
        checkOutput("rst_cpu_rst", cpu_rst, 1);
        checkOutput("rst_load_len", load_len, 0);
        checkOutput("rst_mdrout", MDROut, 0);
        checkOutput("rst_wp_hit", wp_hit, 0);
        rst = 1'b0;

        // Three-word load, then release timing
        loadWord(10'h040, 1'b0);
        loadWord(10'h0C5, 1'b0);
        loadWord(10'h200, 1'b1);
        checkOutput("load3_len", load_len, 3);
        checkOutput("release_ready", ld_ready, 0);
        checkOutput("release_cpu_rst", cpu_rst, 1);
        applyStimulus(1'b1, 10'h3AA, 1'b0, 1'b1, 6'd0, 1'b0, 10'h0);
        checkOutput("run_cpu_rst", cpu_rst, 0);
        checkOutput("run_ready", ld_ready, 0);
        checkOutput("run_len_kept", load_len, 3);
        checkOutput("run_first_mdrout", MDROut, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].chk) expQ.push_back(vecs[i].exp);
            if (vecs[i].wr) modelCpuWrite(vecs[i].mar, vecs[i].din);
            applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, vecs[i].mar, vecs[i].wr, vecs[i].din);
            if (vecs[i].chk) checkOutput(vecs[i].name, MDROut, expQ.pop_front());
        end

        // Reload request with a simultaneous write that must still land
        startReload(6'd20, 1'b1, 10'h2AB);
        checkOutput("reload_cpu_rst", cpu_rst, 1);
        checkOutput("reload_ready", ld_ready, 1);
        checkOutput("reload_len", load_len, 0);
        checkOutput("reload_mdrout", MDROut, 0);
        applyStimulus(1'b0, 10'h0, 1'b1, 1'b0, 6'd21, 1'b1, 10'h111);
        checkOutput("last_no_valid_ready", ld_ready, 1);
        checkOutput("last_no_valid_len", load_len, 0);
        loadWord(10'h011, 1'b0);
        loadWord(10'h022, 1'b1);
        checkOutput("load2_len", load_len, 2);
        idle();
        readCheck("rd20_committed", 6'd20);
        readCheck("rd21_load_write_ignored", 6'd21);
        readCheck("rd1_reload", 6'd1);

        // Full 64-word load without ld_last
        startReload(6'd0, 1'b0, 10'h0);
        for (int i = 0; i < 64; i++) begin
            loadWord(10'((i * 37 + 5) & 10'h3FF), 1'b0);
            if (i == 62) begin
                checkOutput("full63_len", load_len, 63);
                checkOutput("full63_ready", ld_ready, 1);
            end
        end
        checkOutput("full_len", load_len, 64);
        checkOutput("full_ready", ld_ready, 0);
        checkOutput("full_cpu_rst", cpu_rst, 1);
        applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0, 6'd0, 1'b1, 10'h3FF);
        readCheck("full_rd0", 6'd0);
        readCheck("full_rd63", 6'd63);
        readCheck("full_rd20", 6'd20);

        // Reset in the middle of a load
        startReload(6'd0, 1'b0, 10'h0);
        loadWord(10'h0A1, 1'b0);
        loadWord(10'h0A2, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 10'h0A3, 1'b0, 1'b0, 6'd2, 1'b1, 10'h0A4);
        rst = 1'b0;
        wIdx   = 0;
        expLen = 0;
        expWp  = 1'b0;
        checkOutput("midrst_len", load_len, 0);
        checkOutput("midrst_ready", ld_ready, 1);
        checkOutput("midrst_cpu_rst", cpu_rst, 1);
        checkOutput("midrst_mdrout", MDROut, 0);
        loadWord(10'h0B4, 1'b1);
        checkOutput("midrst_len1", load_len, 1);
        idle();
        readCheck("midrst_rd1_persist", 6'd1);
        readCheck("midrst_rd2_persist", 6'd2);
        readCheck("midrst_rd0_new", 6'd0);

        // Write protection of the loaded region
        startReload(6'd0, 1'b0, 10'h0);
        loadWord(10'h101, 1'b0);
        loadWord(10'h102, 1'b0);
        loadWord(10'h103, 1'b0);
        loadWord(10'h104, 1'b1);
        idle();
        modelCpuWrite(6'd2, 10'h2EE);
        applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 6'd2, 1'b1, 10'h2EE);
        checkOutput("wp_hit_low", wp_hit, 32'(expWp));
        modelCpuWrite(6'd4, 10'h2DD);
        applyStimulus(1'b0, 10'h0, 1'b0, 1'b0, 6'd4, 1'b1, 10'h2DD);
        checkOutput("wp_hit_sticky", wp_hit, 32'(expWp));
        readCheck("wp_rd2", 6'd2);
        readCheck("wp_rd4", 6'd4);
        startReload(6'd0, 1'b0, 10'h0);
        checkOutput("wp_hit_cleared", wp_hit, 0);
        checkOutput("wp_reload_len", load_len, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fbcpu_mem_loader.md
FBCPU_MEM_LOADER -- requirements
Module: fbcpu_mem_loader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 6, memory address width; depth = 2^ADDRESS_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 10, memory word width.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports ld_valid input 1, ld_ready output 1, ld_data input DATA_WIDTH and ld_last input 1: program-load stream, one word per handshake.
REQ-006 SHALL have port ld_start  input  1  one-cycle request to reload the program while running.
REQ-007 SHALL have port cpu_rst  output  1  drives the CPU core's rst input.
REQ-008 SHALL have ports MAR input ADDRESS_WIDTH, RAMWr input 1 and MDRIn input DATA_WIDTH: the CPU-side address, write strobe and write data.
REQ-009 SHALL have port MDROut  output  DATA_WIDTH  CPU read data.
REQ-010 SHALL have port load_len  output  ADDRESS_WIDTH+1  number of words accepted in the last load.
REQ-011 SHALL have port wp_hit  output  1  sticky write-protect violation flag.

Function
REQ-012 SHALL implement the FSM LOAD -> RELEASE -> RUN, with RUN -> LOAD on ld_start.
REQ-013 In LOAD: ld_ready=1 and cpu_rst=1; each cycle with ld_valid&ld_ready SHALL write ld_data to mem[wptr], then increment wptr and load_len.
REQ-014 Entry to LOAD SHALL clear wptr and load_len to 0.
REQ-015 Accepting a word with ld_last=1, or accepting the word at wptr = 2^ADDRESS_WIDTH-1 (full), SHALL move the FSM to RELEASE on the next edge; wptr SHALL NOT wrap.
REQ-016 RELEASE SHALL last exactly one cycle with ld_ready=0 and cpu_rst=1, then move to RUN.
REQ-017 In RUN: cpu_rst=0 and ld_ready=0.
REQ-018 In RUN, MDROut SHALL be registered: MDROut <= mem[MAR] at each edge, giving 1-cycle read latency, so a MAR presented in cycle N is valid in cycle N+1.
REQ-019 In RUN, RAMWr=1 SHALL write MDRIn to mem[MAR] at the edge.
REQ-020 A same-address read and write in one cycle SHALL return the old data (read-before-write).
REQ-021 In LOAD and RELEASE, MDROut SHALL be 0 and CPU writes SHALL be ignored.
REQ-022 ld_start in RUN SHALL enter LOAD on the next edge; any CPU write presented in that same cycle SHALL still be committed.
REQ-023 ld_start outside RUN SHALL be ignored.
REQ-024 ld_last with ld_valid=0 SHALL be ignored.

Reset
REQ-025 rst SHALL set the following, from any state including mid-load: state=LOAD, wptr=0, load_len=0, MDROut=0, wp_hit=0, ld_ready=1, cpu_rst=1.
REQ-026 rst SHALL NOT clear memory contents.
REQ-027 rst SHALL take priority over every handshake and write in the same cycle.

Configuration
REQ-028 With macro FBCPU_MEM_WP_EN defined, RUN-state CPU writes with MAR < load_len SHALL be dropped and SHALL set wp_hit=1 until rst or the next LOAD entry.
REQ-029 Without FBCPU_MEM_WP_EN, all RUN writes SHALL commit and wp_hit SHALL be tied 0.

Verification
REQ-030 Scenario: rst, then load 3 words 0x040,0x0C5,0x200 (last on the third) -> load_len=3, cpu_rst falls 2 cycles after the last handshake, and reading MAR=1 gives MDROut=0x0C5 one cycle later.
REQ-031 Scenario: load 64 words with ld_last never asserted -> RELEASE after the 64th word, load_len=64, and mem[0] is not overwritten.
REQ-032 Scenario: in RUN, RAMWr=1, MAR=10, MDRIn=0x155, then a read at MAR=10 -> MDROut=0x155; a same-cycle read returns the prior value.
REQ-033 Scenario: in RUN, assert ld_start together with a write to address 20 -> the write commits, cpu_rst=1 next cycle, ld_ready=1, load_len=0.
REQ-034 Scenario: rst asserted after 2 of 5 load words -> restarts at wptr=0 and the previously loaded words persist in memory.
REQ-035 Scenario: with FBCPU_MEM_WP_EN, load_len=4, write to MAR=2 -> the write is dropped and wp_hit=1; a write to MAR=4 commits.
